// File: rtl/call_stack_pkg.sv
// Shared types and default sizing for the hardware return-address stack.
// Pure declarations: no logic, no latency.
// No flow control; consumers own their handshaking.
package call_stack_pkg;

    localparam int DEF_WIDTH = 15;
    localparam int DEF_DEPTH = 16;

    // Operation selected for the current cycle after priority decode
    typedef enum logic [2:0] {
        STK_NOP,
        STK_PUSH,
        STK_POP,
        STK_REPLACE,
        STK_TOSWR
    } stk_op_e;

endpackage

// File: rtl/call_stack_ram.sv
// DEPTH x WIDTH storage for the return-address stack, one write port, one read port.
// Write takes effect at the clock edge; read is combinational (zero latency).
// No backpressure; every write request is accepted. Contents are not reset.
module stack_ram #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack with occupancy, sticky ovf/unf flags, error pulse and TOS write.
// Results of an operation are visible on outputs one cycle after the operation edge.
// No backpressure; faults are reported via flags/stack_err instead of stalling.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] stack_in,
    input  logic             stvren,
    input  logic             tos_we,
    input  logic [WIDTH-1:0] tos_wdata,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] stack_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf,
    output logic             stack_err
);

    logic [PTR_W-1:0] tp, tp_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_set, unf_set, err_nxt;
    logic             ram_we;
    logic [PTR_W-1:0] ram_waddr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;
    stk_op_e          op;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Decode the operation and compute next pointer, count, write and fault events
    always_comb begin
        op        = STK_NOP;
        tp_nxt    = tp;
        cnt_nxt   = count;
        ram_we    = 1'b0;
        ram_waddr = tp;
        ram_wdata = stack_in;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        err_nxt   = 1'b0;

        // Replace on an empty stack has nothing to replace, so it degrades to a push
        if (push && pop)  op = empty ? STK_PUSH : STK_REPLACE;
        else if (push)    op = STK_PUSH;
        else if (pop)     op = STK_POP;
        else if (tos_we)  op = STK_TOSWR;

        case (op)
            STK_REPLACE: begin
                ram_we = 1'b1;
            end
            STK_PUSH: begin
                if (!full) begin
                    tp_nxt    = tp + PTR_W'(1);
                    ram_waddr = tp + PTR_W'(1);
                    ram_we    = 1'b1;
                    cnt_nxt   = count + CNT_W'(1);
                end else if (!stvren) begin
                    // Circular overwrite of the oldest entry; count saturates at DEPTH
                    tp_nxt    = tp + PTR_W'(1);
                    ram_waddr = tp + PTR_W'(1);
                    ram_we    = 1'b1;
                    ovf_set   = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                    err_nxt = 1'b1;
                end
            end
            STK_POP: begin
                if (!empty) begin
                    tp_nxt  = tp - PTR_W'(1);
                    cnt_nxt = count - CNT_W'(1);
                end else begin
                    unf_set = 1'b1;
                    err_nxt = stvren;
                end
            end
            STK_TOSWR: begin
                ram_we    = !empty;
                ram_wdata = tos_wdata;
            end
            default: ;
        endcase

        // Reset overrides everything, including storage writes
        if (!reset) ram_we = 1'b0;
    end

    // Pointer, occupancy and flag registers; a new fault wins over flag_clr
    always_ff @(posedge clk) begin
        if (!reset) begin
            tp        <= PTR_W'(DEPTH - 1);
            count     <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            tp        <= tp_nxt;
            count     <= cnt_nxt;
            ovf       <= ovf_set | (ovf & ~flag_clr);
            unf       <= unf_set | (unf & ~flag_clr);
            stack_err <= err_nxt;
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (tp),
        .rdata (ram_rdata)
    );

    assign stack_out = empty ? '0 : ram_rdata;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack at WIDTH=15, DEPTH=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants.
module tb_call_stack;

    localparam int WIDTH = 15;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] stack_in = '0;
    logic             stvren = 1'b0;
    logic             tos_we = 1'b0;
    logic [WIDTH-1:0] tos_wdata = '0;
    logic             flag_clr = 1'b0;
    logic [WIDTH-1:0] stack_out;
    logic [CNT_W-1:0] count;
    logic             full, empty, ovf, unf, stack_err;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .stack_in  (stack_in),
        .stvren    (stvren),
        .tos_we    (tos_we),
        .tos_wdata (tos_wdata),
        .flag_clr  (flag_clr),
        .stack_out (stack_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .unf       (unf),
        .stack_err (stack_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Apply one cycle of stimulus, then return inputs to idle
    task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] din,
                        input logic tw, input logic [WIDTH-1:0] twd, input logic fc);
        push = p; pop = q; stack_in = din; tos_we = tw; tos_wdata = twd; flag_clr = fc;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; tos_we = 1'b0; flag_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_out", 32'(stack_out), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_unf", 32'(unf), 0);
        check("rst_err", 32'(stack_err), 0);

        // 1: basic push/pop
        step(1, 0, 15'h0123, 0, 0, 0);
        step(1, 0, 15'h0456, 0, 0, 0);
        check("t1_count2", 32'(count), 2);
        check("t1_out456", 32'(stack_out), 32'h456);
        step(0, 1, 0, 0, 0, 0);
        check("t1_out123", 32'(stack_out), 32'h123);
        check("t1_count1", 32'(count), 1);
        step(0, 1, 0, 0, 0, 0);
        check("t1_empty", 32'(empty), 1);
        check("t1_out0", 32'(stack_out), 0);

        // 2: overflow with halt
        do_reset();
        stvren = 1'b1;
        for (int i = 1; i <= 16; i++) step(1, 0, 15'(i), 0, 0, 0);
        check("t2_full", 32'(full), 1);
        check("t2_err_pre", 32'(stack_err), 0);
        step(1, 0, 15'h7FFF, 0, 0, 0);
        check("t2_err", 32'(stack_err), 1);
        check("t2_ovf", 32'(ovf), 1);
        check("t2_out", 32'(stack_out), 32'h10);
        check("t2_count", 32'(count), 16);
        step(0, 0, 0, 0, 0, 1);
        check("t2_err_gone", 32'(stack_err), 0);
        check("t2_ovf_clr", 32'(ovf), 0);

        // 3: overflow with wrap
        do_reset();
        stvren = 1'b0;
        for (int i = 1; i <= 17; i++) step(1, 0, 15'(i), 0, 0, 0);
        check("t3_ovf", 32'(ovf), 1);
        check("t3_err", 32'(stack_err), 0);
        check("t3_count", 32'(count), 16);
        check("t3_out", 32'(stack_out), 32'h11);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_pop%0d", i), 32'(stack_out), 32'(17 - i));
            step(0, 1, 0, 0, 0, 0);
        end
        check("t3_empty", 32'(empty), 1);

        // 4: underflow, flag clear, set-beats-clear
        do_reset();
        stvren = 1'b1;
        step(0, 1, 0, 0, 0, 0);
        check("t4_unf", 32'(unf), 1);
        check("t4_err", 32'(stack_err), 1);
        check("t4_count", 32'(count), 0);
        step(0, 0, 0, 0, 0, 1);
        check("t4_err_gone", 32'(stack_err), 0);
        check("t4_unf_clr", 32'(unf), 0);
        step(0, 1, 0, 0, 0, 1);
        check("t4_set_wins", 32'(unf), 1);

        // 5: replace
        do_reset();
        stvren = 1'b0;
        step(1, 0, 15'h0AAA, 0, 0, 0);
        step(1, 1, 15'h0BBB, 0, 0, 0);
        check("t5_rep_out", 32'(stack_out), 32'hBBB);
        check("t5_rep_count", 32'(count), 1);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 15'h0CCC, 0, 0, 0);
        check("t5_emp_count", 32'(count), 1);
        check("t5_emp_out", 32'(stack_out), 32'hCCC);
        check("t5_no_unf", 32'(unf), 0);

        // 6: TOS write, tos_we with pop, mid-sequence reset
        do_reset();
        step(1, 0, 15'h0111, 0, 0, 0);
        step(1, 0, 15'h0222, 0, 0, 0);
        step(0, 0, 0, 1, 15'h0333, 0);
        check("t6_tos_out", 32'(stack_out), 32'h333);
        check("t6_tos_count", 32'(count), 2);
        step(0, 1, 0, 1, 15'h0444, 0);
        check("t6_pop_count", 32'(count), 1);
        check("t6_pop_out", 32'(stack_out), 32'h111);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 15'h0555, 0);
        check("t6_tos_empty", 32'(stack_out), 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 15'h0666, 0, 0, 0);
        check("t6_pre_unf", 32'(unf), 1);
        push = 1'b1; stack_in = 15'h0777;
        do_reset();
        push = 1'b0;
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_unf", 32'(unf), 0);
        check("t6_rst_out", 32'(stack_out), 0);
        check("t6_rst_empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Parametrised hardware return-address stack for the PIC16F1826-style core: the successor to the fixed 11-bit, 16-deep call stack.
- Holds program-counter values for CALL/RETURN/interrupt entry.
- Adds:
  - occupancy tracking and full/empty status;
  - sticky overflow/underflow flags;
  - STVREN-style error pulse;
  - wrap-versus-halt mode on overflow;
  - simultaneous push+pop (replace top);
  - software write of the top-of-stack (TOS) entry.
- Sits between the PC logic and the SFR file (STKPTR/TOSH/TOSL view).

Parameters:
- WIDTH, 15, bits per entry (PC width).
- DEPTH, 16, number of entries; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), index width (derived; not overridden).
- CNT_W, $clog2(DEPTH+1), occupancy width (derived; not overridden).

Ports:
- clk  in  1  Single clock; rising edge.
- reset  in  1  Synchronous, active-low reset.
- push  in  1  Push stack_in.
- pop  in  1  Pop top entry.
- stack_in  in  WIDTH  Data to push.
- stvren  in  1  1 = halt on over/underflow and raise stack_err; 0 = wrap/ignore.
- tos_we  in  1  Software write of the top entry.
- tos_wdata  in  WIDTH  Data for tos_we.
- flag_clr  in  1  Clear ovf and unf.
- stack_out  out  WIDTH  Current top entry; 0 when empty.
- count  out  CNT_W  Number of valid entries (0..DEPTH).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf  out  1  Sticky overflow flag.
- unf  out  1  Sticky underflow flag.
- stack_err  out  1  One-cycle pulse on over/underflow when stvren = 1.

Behaviour:
- State:
  - top index tp (PTR_W bits);
  - count (CNT_W bits);
  - ovf, unf, stack_err registers;
  - storage array (not reset).
- Reset (reset = 0 at a clk edge):
  - tp = DEPTH-1, count = 0, ovf = 0, unf = 0, stack_err = 0.
  - Outputs after reset: stack_out = 0, empty = 1, full = 0.
  - Reset overrides every other input in the same cycle.
- stack_out:
  - Combinational read of storage[tp], forced to 0 when count == 0.
  - New value is visible the cycle after the operation edge (1-cycle latency).
  - full and empty are combinational from count.
- Operation decode, priority order (push/pop beat tos_we):
  - REPLACE (push & pop):
    - If count > 0: storage[tp] <= stack_in; tp and count unchanged; no flags.
    - If count == 0: behaves exactly as PUSH.
  - PUSH (push only):
    - If count < DEPTH: tp <= tp+1 (mod DEPTH); storage[tp+1] <= stack_in; count <= count+1.
    - If full and stvren = 0: same write and tp increment (oldest entry overwritten, circular); count stays DEPTH; ovf <= 1.
    - If full and stvren = 1: no write, tp/count unchanged; ovf <= 1; stack_err pulses.
  - POP (pop only):
    - If count > 0: tp <= tp-1 (mod DEPTH); count <= count-1.
    - If count == 0: tp/count unchanged; unf <= 1; stack_err pulses if stvren = 1.
  - TOS write (tos_we, no push/pop):
    - If count > 0: storage[tp] <= tos_wdata.
    - If count == 0: ignored, no flag.
  - tos_we asserted together with push or pop is ignored.
- Flags:
  - stack_err is high for exactly the one cycle after the faulting edge, otherwise 0.
  - ovf and unf hold until flag_clr or reset.
  - flag_clr in the same cycle as a new fault: set wins.
- Arithmetic:
  - All index math is modulo DEPTH (natural PTR_W wrap).
  - count never exceeds DEPTH and never goes negative.

Decomposition:
- Package call_stack_pkg holds:
  - enum stk_op_e {STK_NOP, STK_PUSH, STK_POP, STK_REPLACE, STK_TOSWR};
  - default WIDTH/DEPTH localparams.
- One natural sub-module, stack_ram:
  - DEPTH x WIDTH;
  - one synchronous write port;
  - asynchronous read port.
- call_stack holds the pointer/count FSM, flags and output muxing.

Test Plan (WIDTH=15, DEPTH=16):
1. Reset, then push 0x0123 and 0x0456 on successive cycles -> count=2, stack_out=0x0456; pop -> stack_out=0x0123, count=1; pop -> empty=1, stack_out=0.
2. stvren=1: push 16 values 0x0001..0x0010 -> full=1; 17th push 0x7FFF -> stack_err high exactly one cycle, ovf=1, stack_out=0x0010, count=16.
3. stvren=0: push 17 values 0x0001..0x0011 -> ovf=1, stack_err=0, count=16, stack_out=0x0011; 16 pops return 0x0011 down to 0x0002.
4. Empty stack, pop with stvren=1 -> unf=1, stack_err one-cycle pulse, count=0; flag_clr -> unf=0; flag_clr together with another empty pop -> unf stays 1.
5. Push 0x0AAA, then push+pop with stack_in=0x0BBB -> stack_out=0x0BBB, count=1; on empty stack push+pop 0x0CCC -> count=1, stack_out=0x0CCC.
6. count=2, top 0x0222: tos_we with 0x0333 -> stack_out=0x0333; tos_we+pop together -> pop only, tos_we ignored; drive reset low mid-sequence -> count=0, flags cleared, stack_out=0.
